mem_access_stage: RTL
=====================

# mem_access_stage

Pipeline MEM stage of the 5-stage core: consumes the EX/MEM register outputs, performs the data-memory load/store against an internal word RAM with a configurable wait-state latency, and registers the result into the MEM/WB boundary. While an access is in progress it asserts `stall` so the front of the pipeline (PC, IF/ID, ID/EX, EX/MEM) freezes and the EX/MEM outputs stay constant.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; RAM depth 2^ADDR_WIDTH x 32.
- `WAIT_CYCLES`, 2: extra cycles per memory access, legal range 0..15.

- `clk` in 1: rising-edge clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `reg_write` in 1: WB control, passed through.
- `mem_to_reg` in 1: WB control, passed through.
- `alu_result` in 32: byte address for loads/stores; pass-through value otherwise.
- `write_data` in 32: store data.
- `write_reg_addr` in 5: destination register.
- `stall` out 1: combinational; high = hold all upstream pipeline registers.
- `wb_reg_write` out 1, `wb_mem_to_reg` out 1: registered WB controls.
- `wb_read_data` out 32: registered load data.
- `wb_alu_result` out 32, `wb_write_reg_addr` out 5: registered pass-through.
- `misaligned_err` out 1: sticky misaligned-access flag.

## Operation
- Access = `mem_read | mem_write`. RAM index = `alu_result[ADDR_WIDTH+1:2]`; bits above are ignored (wrap).
- FSM states IDLE, WAIT; 4-bit down-counter `cnt`.
- IDLE, no access: completes in one cycle; at the edge `wb_*` load the inputs, `wb_read_data <= 0`.
- IDLE, access, `WAIT_CYCLES==0`: completes in one cycle (no stall).
- IDLE, access, `WAIT_CYCLES>0`: `stall=1`; next state WAIT, `cnt <= WAIT_CYCLES-1`.
- WAIT, `cnt!=0`: `stall=1`; `cnt <= cnt-1`.
- WAIT, `cnt==0`: `stall=0`; completion edge; state returns to IDLE.
- Completion edge: store commits `write_data` to RAM; load captures `RAM[index]` into `wb_read_data`; all `wb_*` load from the inputs. Store only: `wb_read_data <= 0`.
- `mem_read` and `mem_write` both high: treated as a store with read-first behaviour. `wb_read_data` receives the pre-write word.
- Every edge with `stall=1` loads a bubble: `wb_reg_write <= 0`, `wb_mem_to_reg <= 0`. The other `wb_*` fields hold.
- Stores never touch RAM before the completion edge.
- Reset (any state, including mid-WAIT): state IDLE, `cnt=0`; all `wb_*` = 0; `misaligned_err=0`. A pending store is aborted and not committed. RAM contents are not cleared. `stall` is forced 0 while `reset` is high.

## Timing
- Memory instruction occupies MEM for WAIT_CYCLES+1 cycles. Non-memory instruction occupies it for 1 cycle.
- Load data is valid on `wb_read_data` immediately after the completion edge, i.e. WAIT_CYCLES+1 edges after the instruction is presented.
- `stall` is a combinational function of state, `cnt` and the inputs. It drops in the completion cycle, so EX/MEM advances on the same edge that MEM/WB captures.
- Upstream holds all inputs constant while `stall=1`. Input changes during `stall=1` are undefined behaviour.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - An access with `alu_result[1:0]!=0` is misaligned: no RAM access, no stall, completes in one cycle.
  - The RAM write is suppressed.
  - `wb_reg_write <= 0`, `wb_mem_to_reg <= 0`, `wb_read_data <= 0`.
  - `misaligned_err` is set and stays set until reset.
- Undefined: `alu_result[1:0]` is ignored, every access is treated as aligned, and `misaligned_err` is tied 0.

## Test plan
- WAIT_CYCLES=2. Store `write_data=0xDEADBEEF` at `alu_result=0x10` -> `stall` high for exactly 2 cycles, RAM[4] written on the 3rd edge, `wb_reg_write=0` throughout. Then load from 0x10 with `reg_write=1`, `mem_to_reg=1`, `write_reg_addr=8` -> after 3 edges `wb_read_data=0xDEADBEEF`, `wb_reg_write=1`, `wb_write_reg_addr=8`.
- WAIT_CYCLES=0. Back-to-back store 0x1234 at 0x20, then load from 0x20 -> `stall` never rises; load returns 0x1234 one edge after presentation.
- Non-memory op `alu_result=0x55`, `reg_write=1` -> next edge `wb_alu_result=0x55`, `wb_reg_write=1`, `wb_read_data=0`, no stall.
- Reset asserted in WAIT during a store of 0xCAFEF00D to 0x40 -> next edge all `wb_*`=0, state IDLE, `stall=0`; a later load from 0x40 returns the old contents, not 0xCAFEF00D.
- `mem_read=mem_write=1` at 0x08 holding 0x11, `write_data=0x22` -> `wb_read_data=0x11`; a subsequent load returns 0x22.
- With `MEM_ALIGN_CHECK_EN`: load at 0x13 -> no stall, `wb_reg_write=0`, `misaligned_err=1`, and it stays 1 after later valid accesses until reset.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM/WB signal bundle for the pipeline MEM stage.
// master drives the EX/MEM side and observes results; slave is the MEM stage itself.
interface mem_access_stage_if;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  write_reg_addr;
  logic        stall;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic [31:0] wb_read_data;
  logic [31:0] wb_alu_result;
  logic [4:0]  wb_write_reg_addr;
  logic        misaligned_err;

  modport master (
    output mem_read, mem_write, reg_write, mem_to_reg,
    output alu_result, write_data, write_reg_addr,
    input  stall, wb_reg_write, wb_mem_to_reg, wb_read_data,
    input  wb_alu_result, wb_write_reg_addr, misaligned_err
  );

  modport slave (
    input  mem_read, mem_write, reg_write, mem_to_reg,
    input  alu_result, write_data, write_reg_addr,
    output stall, wb_reg_write, wb_mem_to_reg, wb_read_data,
    output wb_alu_result, wb_write_reg_addr, misaligned_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: word RAM load/store with WAIT_CYCLES wait states, MEM/WB register.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_stage_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  logic [31:0] ram [0:DEPTH-1];

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        stall;
  logic        complete;
  logic        access;
  logic        misaligned;
  logic        mem_access;
  logic [ADDR_WIDTH-1:0] index;

  logic        wb_reg_write_reg;
  logic        wb_mem_to_reg_reg;
  logic [31:0] wb_read_data_reg;
  logic [31:0] wb_alu_result_reg;
  logic [4:0]  wb_write_reg_addr_reg;

  assign access = bus.mem_read | bus.mem_write;
  assign index  = bus.alu_result[ADDR_WIDTH+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned_err_reg;

  assign misaligned         = access && (bus.alu_result[1:0] != 2'b00);
  assign bus.misaligned_err = misaligned_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_err_reg <= 1'b0;
    end else if (misaligned) begin
      misaligned_err_reg <= 1'b1;
    end
  end
`else
  assign misaligned         = 1'b0;
  assign bus.misaligned_err = 1'b0;
`endif

  // Misaligned accesses bypass the RAM entirely and never stall.
  assign mem_access = access && !misaligned;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_access && HAS_WAIT) begin
          stall      = 1'b1;
          state_next = WAIT;
          cnt_next   = WAIT_INIT;
        end else begin
          complete = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          stall    = 1'b1;
          cnt_next = cnt_reg - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      stall    = 1'b0;
      complete = 1'b0;
    end
  end

  // Stores commit only on the completion edge, so a reset mid-WAIT aborts them.
  always_ff @(posedge clk) begin
    if (complete && mem_access && bus.mem_write) begin
      ram[index] <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg             <= IDLE;
      cnt_reg               <= 4'd0;
      wb_reg_write_reg      <= 1'b0;
      wb_mem_to_reg_reg     <= 1'b0;
      wb_read_data_reg      <= 32'd0;
      wb_alu_result_reg     <= 32'd0;
      wb_write_reg_addr_reg <= 5'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (stall) begin
        wb_reg_write_reg  <= 1'b0;
        wb_mem_to_reg_reg <= 1'b0;
      end else begin
        wb_alu_result_reg     <= bus.alu_result;
        wb_write_reg_addr_reg <= bus.write_reg_addr;
        if (misaligned) begin
          wb_reg_write_reg  <= 1'b0;
          wb_mem_to_reg_reg <= 1'b0;
          wb_read_data_reg  <= 32'd0;
        end else begin
          wb_reg_write_reg  <= bus.reg_write;
          wb_mem_to_reg_reg <= bus.mem_to_reg;
          // Read-first: a combined read+write returns the word before the store.
          wb_read_data_reg  <= bus.mem_read ? ram[index] : 32'd0;
        end
      end
    end
  end

  assign bus.stall             = stall;
  assign bus.wb_reg_write      = wb_reg_write_reg;
  assign bus.wb_mem_to_reg     = wb_mem_to_reg_reg;
  assign bus.wb_read_data      = wb_read_data_reg;
  assign bus.wb_alu_result     = wb_alu_result_reg;
  assign bus.wb_write_reg_addr = wb_write_reg_addr_reg;

endmodule
